pipe_trace_monitor: RTL and testbench

Parametrised, synthesisable pipeline tracker for the MIPS32 core: it shadows an N-stage in-order pipeline from fetch PC/instruction plus stall/flush controls. It exposes per-stage PC/instruction/valid, a one-per-cycle retire port, and saturating performance counters with per-class retire counts. It supersedes the fixed 5-stage bench-only stage tracker and sits beside `cpu`, driven from its fetch and hazard signals.

---
 rtl/pipe_trace_pkg.sv | 19 +
 rtl/pipe_trace_monitor_classifier.sv | 26 ++
 rtl/pipe_trace_monitor.sv | 145 ++++++++++++++
 tb/tb_pipe_trace_monitor.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_trace_pkg.sv
// Shared types and MIPS32 opcode constants for the pipeline trace monitor.
package pipe_trace_pkg;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_NONE
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

endpackage

// File: rtl/pipe_trace_monitor_classifier.sv
// Combinational opcode decode of a retiring instruction into its performance-counter class.
module instr_classifier
  import pipe_trace_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] instr,
  output instr_class_t    instr_class
);

  // Only the major opcode matters; the remaining bits are folded away here.
  logic unused_operand_bits;
  assign unused_operand_bits = ^instr[XLEN-7:0];

  always_comb begin
    instr_class = CLS_NONE;
    case (instr[XLEN-1 -: 6])
      OP_RTYPE, OP_ADDI: instr_class = CLS_ALU;
      OP_LW:             instr_class = CLS_LOAD;
      OP_SW:             instr_class = CLS_STORE;
      OP_BEQ, OP_BNE:    instr_class = CLS_BRANCH;
      default:           instr_class = CLS_NONE;
    endcase
  end

endmodule

// File: rtl/pipe_trace_monitor.sv
// Shadow tracker of an N-stage in-order pipeline with retire port and saturating counters.
// Optional repeated-fetch-PC auto-stall is enabled by defining PIPE_TRACE_AUTOSTALL_EN.
module pipe_trace_monitor
  import pipe_trace_pkg::*;
#(
  parameter int STAGES      = 5,
  parameter int XLEN        = 32,
  parameter int STALL_STAGE = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [XLEN-1:0]        fetch_pc,
  input  logic [XLEN-1:0]        fetch_instr,
  input  logic                   stall,
  input  logic                   flush,
  output logic [STAGES*XLEN-1:0] stage_pc,
  output logic [STAGES*XLEN-1:0] stage_instr,
  output logic [STAGES-1:0]      stage_valid,
  output logic                   retire_valid,
  output logic [XLEN-1:0]        retire_pc,
  output logic [XLEN-1:0]        retire_instr,
  output logic [CNT_W-1:0]       cycle_cnt,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic [CNT_W-1:0]       stall_cnt,
  output logic [CNT_W-1:0]       flush_cnt,
  output logic [4*CNT_W-1:0]     class_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value, input logic en);
    return (en && (value != '1)) ? value + CNT_W'(1) : value;
  endfunction

  logic stall_eff;

`ifdef PIPE_TRACE_AUTOSTALL_EN
  // A fetch PC seen twice in a row means the front end is stalled even without a hazard.
  logic [XLEN-1:0] prev_pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) prev_pc <= '1;
    else       prev_pc <= fetch_pc;
  end

  assign stall_eff = stall | (fetch_pc == prev_pc);
`else
  assign stall_eff = stall;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit FLUSHED = (k < FLUSH_DEPTH);
    localparam bit HELD    = (k < STALL_STAGE);
    localparam bit BUBBLED = (k == STALL_STAGE);

    logic [XLEN-1:0] pc_r, instr_r, src_pc, src_instr;
    logic            valid_r, src_valid;

    if (k == 0) begin : g_src
      // A zero instruction word is a bubble and carries a zero PC.
      assign src_valid = |fetch_instr;
      assign src_instr = fetch_instr;
      assign src_pc    = src_valid ? fetch_pc : '0;
    end else begin : g_src
      assign src_valid = stage_valid[k-1];
      assign src_instr = stage_instr[(k-1)*XLEN +: XLEN];
      assign src_pc    = stage_pc[(k-1)*XLEN +: XLEN];
    end

    // Flush outranks stall, so a squashed stage never holds stale contents.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        pc_r    <= '0;
        instr_r <= '0;
        valid_r <= 1'b0;
      end else if (flush && FLUSHED) begin
        pc_r    <= '0;
        instr_r <= '0;
        valid_r <= 1'b0;
      end else if (stall_eff && HELD) begin
        pc_r    <= pc_r;
        instr_r <= instr_r;
        valid_r <= valid_r;
      end else if (stall_eff && BUBBLED) begin
        pc_r    <= '0;
        instr_r <= '0;
        valid_r <= 1'b0;
      end else begin
        pc_r    <= src_pc;
        instr_r <= src_instr;
        valid_r <= src_valid;
      end
    end

    assign stage_pc[k*XLEN +: XLEN]    = pc_r;
    assign stage_instr[k*XLEN +: XLEN] = instr_r;
    assign stage_valid[k]              = valid_r;
  end

  assign retire_valid = stage_valid[STAGES-1];
  assign retire_pc    = stage_pc[(STAGES-1)*XLEN +: XLEN];
  assign retire_instr = stage_instr[(STAGES-1)*XLEN +: XLEN];

  instr_class_t retire_class;
  logic [3:0]   class_hit;

  instr_classifier #(.XLEN(XLEN)) u_classifier (
    .instr       (retire_instr),
    .instr_class (retire_class)
  );

  always_comb begin
    class_hit = '0;
    case (retire_class)
      CLS_ALU:    class_hit[0] = 1'b1;
      CLS_LOAD:   class_hit[1] = 1'b1;
      CLS_STORE:  class_hit[2] = 1'b1;
      CLS_BRANCH: class_hit[3] = 1'b1;
      default:    class_hit    = '0;
    endcase
  end

  logic [3:0][CNT_W-1:0] class_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
      class_q    <= '0;
    end else begin
      cycle_cnt  <= sat_inc(cycle_cnt, 1'b1);
      retire_cnt <= sat_inc(retire_cnt, retire_valid);
      stall_cnt  <= sat_inc(stall_cnt, stall_eff);
      flush_cnt  <= sat_inc(flush_cnt, flush);
      for (int i = 0; i < 4; i++) begin
        class_q[i] <= sat_inc(class_q[i], retire_valid & class_hit[i]);
      end
    end
  end

  assign class_cnt = class_q;

endmodule

// File: tb/tb_pipe_trace_monitor.sv
// Directed bench for pipe_trace_monitor: retire scoreboard plus counter and stage checks.
// A second, 4-bit-counter instance streams ADDIs to exercise counter saturation.
module tb_pipe_trace_monitor;

  localparam int STAGES = 5;
  localparam int XLEN   = 32;

  logic                   clock, reset;
  logic [XLEN-1:0]        fetch_pc, fetch_instr;
  logic                   stall, flush;
  logic [STAGES*XLEN-1:0] stage_pc, stage_instr;
  logic [STAGES-1:0]      stage_valid;
  logic                   retire_valid;
  logic [XLEN-1:0]        retire_pc, retire_instr;
  logic [15:0]            cycle_cnt, retire_cnt, stall_cnt, flush_cnt;
  logic [63:0]            class_cnt;

  logic [XLEN-1:0]        sat_fetch_pc, sat_fetch_instr;
  logic [STAGES*XLEN-1:0] sat_stage_pc, sat_stage_instr;
  logic [STAGES-1:0]      sat_stage_valid;
  logic                   sat_retire_valid;
  logic [XLEN-1:0]        sat_retire_pc, sat_retire_instr;
  logic [3:0]             sat_cycle_cnt, sat_retire_cnt, sat_stall_cnt, sat_flush_cnt;
  logic [15:0]            sat_class_cnt;

  pipe_trace_monitor #(.STAGES(STAGES), .XLEN(XLEN), .STALL_STAGE(2), .FLUSH_DEPTH(2), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .fetch_pc(fetch_pc), .fetch_instr(fetch_instr),
    .stall(stall), .flush(flush), .stage_pc(stage_pc), .stage_instr(stage_instr),
    .stage_valid(stage_valid), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instr(retire_instr), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .class_cnt(class_cnt)
  );

  pipe_trace_monitor #(.STAGES(STAGES), .XLEN(XLEN), .STALL_STAGE(2), .FLUSH_DEPTH(2), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .fetch_pc(sat_fetch_pc), .fetch_instr(sat_fetch_instr),
    .stall(1'b0), .flush(1'b0), .stage_pc(sat_stage_pc), .stage_instr(sat_stage_instr),
    .stage_valid(sat_stage_valid), .retire_valid(sat_retire_valid), .retire_pc(sat_retire_pc),
    .retire_instr(sat_retire_instr), .cycle_cnt(sat_cycle_cnt), .retire_cnt(sat_retire_cnt),
    .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt), .class_cnt(sat_class_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    int          exp_edge;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  sb_entry_t mon_e;
  int checks = 0, errors = 0, edge_num = 0;
  int exp_stall = 0, exp_flush = 0, exp_retire = 0;
  int exp_class[4] = '{default: 0};
`ifdef PIPE_TRACE_AUTOSTALL_EN
  logic [31:0] prev_pc_model = '1;
`endif

  function automatic int classOf(input logic [31:0] ins);
    case (ins[31:26])
      6'h00, 6'h08: return 0;
      6'h23:        return 1;
      6'h2B:        return 2;
      6'h04, 6'h05: return 3;
      default:      return 4;
    endcase
  endfunction

  function automatic logic [31:0] pcOf(input int k);
    return stage_pc[k*XLEN +: XLEN];
  endfunction

  function automatic logic [31:0] instrOf(input int k);
    return stage_instr[k*XLEN +: XLEN];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One clock edge of stimulus; the retire scoreboard learns what should come out.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ins,
                               input logic st, input logic fl);
    logic eff;
    eff = st;
`ifdef PIPE_TRACE_AUTOSTALL_EN
    if (pc == prev_pc_model) eff = 1'b1;
    prev_pc_model = pc;
`endif
    fetch_pc        = pc;
    fetch_instr     = ins;
    stall           = st;
    flush           = fl;
    sat_fetch_pc    = sat_fetch_pc + 32'd4;
    sat_fetch_instr = 32'h2042_0001;
    @(posedge clock);
    edge_num++;
    if (eff) exp_stall++;
    if (fl)  exp_flush++;
    if (!eff && !fl && ins != 32'd0) sb_q.push_back('{pc, ins, edge_num + STAGES - 1});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0000_8000 + 32'(edge_num) * 32'd4, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic delayEntry(input logic [31:0] pc);
    foreach (sb_q[i]) if (sb_q[i].pc == pc) sb_q[i].exp_edge++;
  endtask

  task automatic dropLast(input int n);
    for (int i = 0; i < n; i++) void'(sb_q.pop_back());
  endtask

  task automatic checkCounters();
    checkOutput("cycle_cnt", 64'(cycle_cnt), 64'(edge_num));
    checkOutput("retire_cnt", 64'(retire_cnt), 64'(exp_retire));
    checkOutput("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
    checkOutput("flush_cnt", 64'(flush_cnt), 64'(exp_flush));
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("class_cnt[%0d]", i), 64'(class_cnt[i*16 +: 16]), 64'(exp_class[i]));
  endtask

  // Retire monitor: every visible retirement must match the oldest outstanding fetch.
  always @(negedge clock) begin
    if (!reset && retire_valid) begin
      checkOutput("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        checkOutput("retire_pc", 64'(retire_pc), 64'(mon_e.pc));
        checkOutput("retire_instr", 64'(retire_instr), 64'(mon_e.instr));
        checkOutput("retire_edge", 64'(edge_num), 64'(mon_e.exp_edge));
        exp_retire++;
        if (classOf(mon_e.instr) < 4) exp_class[classOf(mon_e.instr)]++;
      end
    end
  end

  initial begin
    reset = 1'b0; fetch_pc = '0; fetch_instr = '0; stall = 1'b0; flush = 1'b0;
    sat_fetch_pc = '0; sat_fetch_instr = '0;
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_stage_valid", 64'(stage_valid), 64'd0);
    checkOutput("rst_stage_pc_any", 64'(|stage_pc), 64'd0);
    checkOutput("rst_stage_instr_any", 64'(|stage_instr), 64'd0);
    checkOutput("rst_retire_valid", 64'(retire_valid), 64'd0);
    checkOutput("rst_counters", {cycle_cnt, retire_cnt, stall_cnt, flush_cnt}, 64'd0);
    checkOutput("rst_class_cnt", class_cnt, 64'd0);
    checkOutput("rst_sat_cycle", 64'(sat_cycle_cnt), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;

    // Single load: visible at retire exactly STAGES edges after fetch.
    applyStimulus(32'h0, 32'h8C0A_0004, 1'b0, 1'b0);
    checkOutput("t1_no_early_retire_e1", 64'(retire_valid), 64'd0);
    for (int i = 2; i <= 4; i++) begin
      idle(1);
      checkOutput($sformatf("t1_no_early_retire_e%0d", i), 64'(retire_valid), 64'd0);
    end
    idle(1);
    checkOutput("t1_retire_valid_e5", 64'(retire_valid), 64'd1);
    checkOutput("t1_retire_pc_e5", 64'(retire_pc), 64'd0);
    idle(1);
    checkOutput("t1_retire_cnt", 64'(retire_cnt), 64'd1);
    checkOutput("t1_load_cnt", 64'(class_cnt[31:16]), 64'd1);

    // Stall while PC 8 sits in stage 1.
    applyStimulus(32'd0,  32'h2001_0001, 1'b0, 1'b0);
    applyStimulus(32'd4,  32'h0022_1820, 1'b0, 1'b0);
    applyStimulus(32'd8,  32'hAC03_0008, 1'b0, 1'b0);
    applyStimulus(32'd12, 32'h1000_0002, 1'b0, 1'b0);
    checkOutput("t2_pc8_in_s1", 64'(pcOf(1)), 64'd8);
    delayEntry(32'd8);
    delayEntry(32'd12);
    applyStimulus(32'h0FC, 32'h8C02_0010, 1'b1, 1'b0);
    checkOutput("t2_stage_valid", 64'(stage_valid), 64'b11011);
    checkOutput("t2_s2_bubble_pc", 64'(pcOf(2)), 64'd0);
    checkOutput("t2_s2_bubble_instr", 64'(instrOf(2)), 64'd0);
    checkOutput("t2_s1_held", 64'(pcOf(1)), 64'd8);
    checkOutput("t2_s0_held", 64'(pcOf(0)), 64'd12);
    checkOutput("t2_s3_advanced", 64'(pcOf(3)), 64'd4);
    applyStimulus(32'd16, 32'h8C02_0010, 1'b0, 1'b0);
    idle(5);
    checkOutput("t2_stall_cnt", 64'(stall_cnt), 64'd1);
    checkOutput("t2_retire_cnt", 64'(retire_cnt), 64'd6);
    checkCounters();

    // Flush squashes PC 12 (in stage 0) and PC 16 (at fetch).
    applyStimulus(32'd0,  32'h2001_0005, 1'b0, 1'b0);
    applyStimulus(32'd4,  32'h0800_0010, 1'b0, 1'b0);
    applyStimulus(32'd8,  32'h1422_0003, 1'b0, 1'b0);
    applyStimulus(32'd12, 32'hAC04_0000, 1'b0, 1'b0);
    dropLast(1);
    applyStimulus(32'd16, 32'h8C05_0000, 1'b0, 1'b1);
    checkOutput("t3_stage_valid", 64'(stage_valid), 64'b11100);
    checkOutput("t3_s2_pc", 64'(pcOf(2)), 64'd8);
    checkOutput("t3_s1_pc", 64'(pcOf(1)), 64'd0);
    idle(4);
    checkOutput("t3_flush_cnt", 64'(flush_cnt), 64'd1);
    checkCounters();

    // Stall and flush on the same edge.
    applyStimulus(32'h40, 32'h2006_0001, 1'b0, 1'b0);
    applyStimulus(32'h44, 32'h00C6_3020, 1'b0, 1'b0);
    applyStimulus(32'h48, 32'h8C07_0000, 1'b0, 1'b0);
    applyStimulus(32'h4C, 32'hAC07_0004, 1'b0, 1'b0);
    dropLast(2);
    applyStimulus(32'h50, 32'h0000_0020, 1'b1, 1'b1);
    checkOutput("t4_stage_valid", 64'(stage_valid), 64'b11000);
    checkOutput("t4_s2_pc", 64'(pcOf(2)), 64'd0);
    checkOutput("t4_s3_pc", 64'(pcOf(3)), 64'h44);
    checkOutput("t4_s4_pc", 64'(pcOf(4)), 64'h40);
    idle(3);
    checkOutput("t4_stall_cnt", 64'(stall_cnt), 64'd2);
    checkOutput("t4_flush_cnt", 64'(flush_cnt), 64'd2);
    checkCounters();

    // Repeated fetch PC with no hazard signal.
    applyStimulus(32'd40, 32'h2003_0001, 1'b0, 1'b0);
`ifdef PIPE_TRACE_AUTOSTALL_EN
    delayEntry(32'd40);
    applyStimulus(32'd40, 32'h2003_0003, 1'b0, 1'b0);
    checkOutput("t5_stage_valid_low", 64'(stage_valid[2:0]), 64'b001);
    checkOutput("t5_stall_cnt", 64'(stall_cnt), 64'd3);
`else
    applyStimulus(32'd40, 32'h2003_0003, 1'b0, 1'b0);
    checkOutput("t5_s0_pc", 64'(pcOf(0)), 64'd40);
    checkOutput("t5_s1_pc", 64'(pcOf(1)), 64'd40);
    checkOutput("t5_stall_cnt", 64'(stall_cnt), 64'd2);
`endif
    idle(6);
    checkCounters();

    // 4-bit counters have long since passed 15 retiring ADDIs.
    checkOutput("sat_cycle_cnt", 64'(sat_cycle_cnt), 64'd15);
    checkOutput("sat_retire_cnt", 64'(sat_retire_cnt), 64'd15);
    checkOutput("sat_alu_cnt", 64'(sat_class_cnt[3:0]), 64'd15);
    checkOutput("sat_other_cnt", 64'(sat_class_cnt[15:4]), 64'd0);
    checkOutput("sat_stall_flush", 64'({sat_stall_cnt, sat_flush_cnt}), 64'd0);

    // Asynchronous reset mid-stream, then a clean restart.
    applyStimulus(32'h200, 32'h2008_0001, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checkOutput("mid_rst_stage_valid", 64'(stage_valid), 64'd0);
    checkOutput("mid_rst_stage_pc_any", 64'(|stage_pc), 64'd0);
    checkOutput("mid_rst_counters", {cycle_cnt, retire_cnt, stall_cnt, flush_cnt}, 64'd0);
    checkOutput("mid_rst_class_cnt", class_cnt, 64'd0);
    sb_q.delete();
    edge_num = 0; exp_stall = 0; exp_flush = 0; exp_retire = 0;
    exp_class = '{default: 0};
`ifdef PIPE_TRACE_AUTOSTALL_EN
    prev_pc_model = '1;
`endif
    @(negedge clock) reset = 1'b0;
    applyStimulus(32'h300, 32'h8C06_0000, 1'b0, 1'b0);
    checkOutput("post_rst_stage_valid", 64'(stage_valid), 64'b00001);
    checkOutput("post_rst_s0_pc", 64'(pcOf(0)), 64'h300);
    idle(5);
    checkCounters();
    checkOutput("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
